// File: rtl/sram_lsu_pkg.sv
// Shared types and constants for the SRAM load/store port.
// Optional misalignment checking is enabled by defining SRAM_LSU_ALIGN_CHK_EN.
package sram_lsu_pkg;

  localparam int BYTE_ADDR_W = 11;
  localparam int WORD_ADDR_W = BYTE_ADDR_W - 2;

  typedef enum logic [1:0] {
    SZ_B   = 2'd0,
    SZ_H   = 2'd1,
    SZ_W   = 2'd2,
    SZ_RSV = 2'd3
  } size_e;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  // Byte lane where the access starts. Low address bits that the access size
  // cannot use are dropped, so a half uses addr[1] only and a word starts at lane 0.
  function automatic logic [1:0] lane_off(input size_e size, input logic [1:0] addr_lo);
    case (size)
      SZ_B:    return addr_lo;
      SZ_H:    return {addr_lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  // True when the low address bits do not suit the access size.
  function automatic logic misaligned(input size_e size, input logic [1:0] addr_lo);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return addr_lo[0];
      SZ_W:    return |addr_lo;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/sram_lsu_rsp_fifo.sv
// Two-entry response queue between the capture stage and the core.
// Pointers are one bit and wrap modulo 2; the head entry is always presented.
module sram_lsu_rsp_fifo
  import sram_lsu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  rsp_t       push_data,
  input  logic       pop,
  output rsp_t       head,
  output logic [1:0] count,
  output logic       full,
  output logic       empty
);

  rsp_t slots [2];
  logic wr_ptr;
  logic rd_ptr;

  // Payload write.
  // NOTE: slot storage has no reset; a slot is only read once count says it holds data.
  always_ff @(posedge clk) begin
    if (push) slots[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; push and pop together leave the count unchanged.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head  = slots[rd_ptr];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

endmodule

// File: rtl/sram_lsu_port.sv
// Core-facing load/store port driving port 0 (RW) of the 32x512 data SRAM.
// SRAM controls are combinational from the accepted request; read data is
// captured one cycle later, aligned, extended and queued in a 2-entry FIFO.
// Define SRAM_LSU_ALIGN_CHK_EN to flag misaligned requests on rsp_err instead
// of silently dropping the unusable low address bits.
module sram_lsu_port
  import sram_lsu_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [BYTE_ADDR_W-1:0] req_addr,
  input  logic [1:0]             req_size,
  input  logic                   req_unsigned,
  input  logic [31:0]            req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [31:0]            rsp_rdata,
`ifdef SRAM_LSU_ALIGN_CHK_EN
  output logic                   rsp_err,
`endif
  output logic                   sram_csb0,
  output logic                   sram_web0,
  output logic [3:0]             sram_wmask0,
  output logic [WORD_ADDR_W-1:0] sram_addr0,
  output logic [31:0]            sram_din0,
  input  logic [31:0]            sram_dout0
);

  size_e      req_sz;
  logic [1:0] req_off;
  logic       req_err;
  logic       accept;

  // Issue register: what the capture stage needs to interpret dout0.
  logic       inflight_v;
  logic       inflight_we;
  size_e      inflight_size;
  logic       inflight_uns;
  logic [1:0] inflight_off;
  logic       inflight_err;

  // Capture stage and response queue.
  logic [31:0] shifted;
  logic [31:0] load_data;
  rsp_t        push_data;
  rsp_t        head;
  logic [1:0]  fifo_count;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;
  logic        at_capacity;

  assign req_sz  = size_e'(req_size);
  assign req_off = lane_off(req_sz, req_addr[1:0]);

`ifdef SRAM_LSU_ALIGN_CHK_EN
  assign req_err = misaligned(req_sz, req_addr[1:0]);
`else
  assign req_err = 1'b0;
`endif

  // Occupancy counts the in-flight access as well as the queued ones, so the
  // capture stage always has a free slot. A full pipe still accepts on a pop.
  assign at_capacity = fifo_full || (inflight_v && (fifo_count == 2'd1));
  assign pop         = rsp_valid && rsp_ready;
  assign req_ready   = rst_n && (!at_capacity || pop);
  assign accept      = req_valid && req_ready;

  // A misaligned request completes without touching the SRAM.
  assign sram_csb0  = !(accept && !req_err);
  assign sram_web0  = !req_we;
  assign sram_addr0 = req_addr[BYTE_ADDR_W-1:2];

  // Byte-lane write mask and lane-replicated store data.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sram_wmask0 = 4'b1111;
    sram_din0   = req_wdata;
    case (req_sz)
      SZ_B: begin
        sram_din0 = {4{req_wdata[7:0]}};
        if (req_we) sram_wmask0 = 4'b0001 << req_off;
      end
      SZ_H: begin
        sram_din0 = {2{req_wdata[15:0]}};
        if (req_we) sram_wmask0 = 4'b0011 << req_off;
      end
      default: begin
        sram_din0   = req_wdata;
        sram_wmask0 = 4'b1111;
      end
    endcase
  end

  // Issue stage: remember the accepted access until its data comes back.
  // The effective lane offset is stored so capture needs no size decoding of addr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_v    <= 1'b0;
      inflight_we   <= 1'b0;
      inflight_size <= SZ_W;
      inflight_uns  <= 1'b0;
      inflight_off  <= 2'b00;
      inflight_err  <= 1'b0;
    end else begin
      inflight_v <= accept;
      if (accept) begin
        inflight_we   <= req_we;
        inflight_size <= req_sz;
        inflight_uns  <= req_unsigned;
        inflight_off  <= req_off;
        inflight_err  <= req_err;
      end
    end
  end

  // Capture stage: right-align the addressed lanes and extend by size.
  always_comb begin
    shifted   = sram_dout0 >> {inflight_off, 3'b000};
    load_data = shifted;
    case (inflight_size)
      SZ_B: load_data = inflight_uns ? {24'h0, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
      SZ_H: load_data = inflight_uns ? {16'h0, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
    push_data.rdata = (inflight_we || inflight_err) ? 32'h0 : load_data;
    push_data.err   = inflight_err;
  end

  sram_lsu_rsp_fifo u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_v),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Response outputs read as zero when no response is present; an error
  // response never carries data.
  assign rsp_valid = !fifo_empty;
  assign rsp_rdata = (rsp_valid && !head.err) ? head.rdata : 32'h0;
`ifdef SRAM_LSU_ALIGN_CHK_EN
  assign rsp_err   = rsp_valid && head.err;
`endif

endmodule

// File: doc/sram_lsu_port.md
# sram_lsu_port

Initiator-side controller for port 0 (RW) of the 32x512 data SRAM. Accepts byte/half/word load and store requests from the core over a valid/ready interface, and drives `csb0`/`web0`/`wmask0`/`addr0`/`din0` with correct byte lanes. Captures `dout0` one cycle after issue, then aligns and sign- or zero-extends it. Buffers responses in a 2-entry queue so that back-to-back accesses sustain one request per cycle.

## Interface
- `BYTE_ADDR_W`, 11: byte address width (512 words x 4 bytes).
- `WORD_ADDR_W`, 9: SRAM word address width; equals `BYTE_ADDR_W-2`.
- `clk`  in  1  single clock; also drives the SRAM `clk0` at top level.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid && req_ready` at the rising edge.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  `BYTE_ADDR_W`  byte address.
- `req_size`  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
- `req_unsigned`  in  1  zero-extend loads when 1; sign-extend when 0.
- `req_wdata`  in  32  store data, right-aligned.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed when `rsp_valid && rsp_ready`.
- `rsp_rdata`  out  32  extended load data; 0 for stores.
- `rsp_err`  out  1  misalignment error. Present only with `SRAM_LSU_ALIGN_CHK_EN`.
- `sram_csb0`  out  1  active-low chip select.
- `sram_web0`  out  1  active-low write enable.
- `sram_wmask0`  out  4  byte write mask.
- `sram_addr0`  out  `WORD_ADDR_W`  word address, `req_addr[BYTE_ADDR_W-1:2]`.
- `sram_din0`  out  32  lane-replicated store data.
- `sram_dout0`  in  32  SRAM read data.

## Operation
- SRAM outputs are combinational from the request.
  - `sram_csb0 = !(req_valid && req_ready)`.
  - `sram_web0 = !req_we`.
- `sram_wmask0` by size and `addr[1:0]`:
  - byte: one-hot `1<<addr[1:0]`.
  - half: `4'b0011` when `addr[1]=0`, `4'b1100` when `addr[1]=1`.
  - word: `4'b1111`.
  - loads: `4'b1111`.
- `sram_din0` replication: byte → `{4{wdata[7:0]}}`; half → `{2{wdata[15:0]}}`; word → `wdata`.
- Issue stage: on acceptance, register `inflight_v`, `we`, `size`, `unsigned`, `addr[1:0]`, and `err`.
- Capture stage: at the next edge, when `inflight_v` is set, write one entry into the response FIFO.
  - Loads: shift `sram_dout0` right by `8*addr[1:0]`, then extend by size and `unsigned`.
  - Stores: `rdata = 0`.
- Response FIFO: 2 entries. Head drives `rsp_*`. Pops on `rsp_valid && rsp_ready`.
- Flow control: `req_ready = (fifo_count + inflight_v) < 2`, or `== 2` with a pop this cycle. With `rsp_ready` held high, one request is accepted per cycle.
- Write-then-read to the same address back-to-back returns the new data. The SRAM writes on the falling edge of the write cycle, so no hazard logic is needed.
- `req_size == 3` without the macro is treated as a word access.

## Timing
- Request accepted at edge N. SRAM registers its inputs at edge N; `dout0` is valid from the falling edge of N until edge N+1.
- Read data is captured at edge N+1. `rsp_valid` is high from edge N+1, so load latency is 1 cycle when the FIFO is empty.
- Reset values:
  - `req_ready = 0`, `rsp_valid = 0`, `rsp_rdata = 0`, `rsp_err = 0`.
  - `sram_csb0 = 1`; `req_ready = 0` is forced while `rst_n` is low.
  - `inflight_v = 0`, FIFO empty.
- Reset mid-operation: the in-flight access and all queued responses are discarded. A store already registered by the SRAM still completes.
- FIFO boundaries:
  - Full with no pop: `req_ready = 0`.
  - Full with a pop: push and pop in the same cycle are allowed, and the count holds.
  - Empty: `rsp_valid = 0`.
- Pointers are 1 bit and wrap modulo 2.

## Configuration
- `SRAM_LSU_ALIGN_CHK_EN` defined:
  - Half with `addr[0]=1`, word with `addr[1:0]!=0`, and size 3 are flagged misaligned.
  - A misaligned request is accepted but does not access the SRAM: `sram_csb0 = 1` for that cycle.
  - Its response carries `rsp_err = 1` and `rsp_rdata = 0`, with the same 1-cycle latency.
- Undefined:
  - The `rsp_err` port is absent.
  - Misaligned low address bits are ignored: half uses `addr[1]`, word uses `addr[1:0]=0`.

## Structure
- Package `sram_lsu_pkg`:
  - `size_e` enum (`SZ_B`, `SZ_H`, `SZ_W`, `SZ_RSV`).
  - `BYTE_ADDR_W` and `WORD_ADDR_W` constants.
  - `rsp_t` struct (`rdata`, `err`).
- Sub-module `sram_lsu_rsp_fifo`: 2-entry `rsp_t` FIFO with `push`/`pop`/`count`/`full`/`empty`.
- Lane steering, extension, and the issue register stay in `sram_lsu_port`.

## Test plan
- Store word `0xDEADBEEF` at 0x010, then load word at 0x010 → wmask `1111`, `addr0 = 4`, and `rsp_rdata = 0xDEADBEEF` one cycle after acceptance.
- Store byte `0x80` at 0x013, then load byte signed and unsigned at 0x013 → wmask `1000`, `din0 = 0x80808080`; responses `0xFFFFFF80` and `0x00000080`.
- Half store `0x1234` at 0x022, then load half at 0x020 and 0x022 → 0x022 returns `0x00001234`; 0x020 returns the old low half.
- `rsp_ready = 0` with 3 back-to-back loads → two accepted, `req_ready` drops. Raising `rsp_ready` drains responses in order, then the third is accepted.
- 8 loads with `rsp_ready = 1` → 8 accepts in 8 consecutive cycles, responses in order.
- `rst_n` pulsed low with 2 queued responses → `rsp_valid = 0` immediately, `sram_csb0 = 1`, no stale response after release.
- With the macro, load word at 0x011 → `csb0` stays 1 and `rsp_err = 1` next cycle. Without it, the same load returns the word at 0x010.
